// File: rtl/exmem_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : exmem_skid_stage
// Description : EX/MEM pipeline stage with a valid/ready handshake and a
//               two-entry skid buffer (main = head, skid = overflow).
//               in_ready is registered, so MEM back-pressure never reaches
//               EX through combinational logic. A synchronous flush turns
//               the stage into a bubble; control outputs are masked when
//               no valid entry is held.
// Revision    : 1.0 - initial release
// ============================================================================
module exmem_skid_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int CTRLW  = 9,
    parameter int RWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [CTRLW-1:0]  ctrl_in,
    input  logic [DWIDTH-1:0] aluout_in,
    input  logic [2:0]        flags_in,
    input  logic [RWIDTH-1:0] regdst_in,
    input  logic [RWIDTH-1:0] rt_in,
    input  logic [DWIDTH-1:0] regdata2_in,
    input  logic [AWIDTH-1:0] branaddr_in,
    input  logic [AWIDTH-1:0] jmpaddr_in,
    input  logic [AWIDTH-1:0] pcnext_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRLW-1:0]  ctrl_out,
    output logic [DWIDTH-1:0] aluout_out,
    output logic [2:0]        flags_out,
    output logic [RWIDTH-1:0] regdst_out,
    output logic [RWIDTH-1:0] rt_out,
    output logic [DWIDTH-1:0] regdata2_out,
    output logic [AWIDTH-1:0] branaddr_out,
    output logic [AWIDTH-1:0] jmpaddr_out,
    output logic [AWIDTH-1:0] pcnext_out,
    output logic [1:0]        occupancy
);

    localparam int PW = CTRLW + 2*DWIDTH + 3 + 2*RWIDTH + 3*AWIDTH;

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_main;
    logic [PW-1:0]   r_skid;
    logic [PW-1:0]   w_payload_in;
    logic [CTRLW-1:0] w_main_ctrl;
    logic            r_main_valid;
    logic            r_in_ready;
    logic [1:0]      r_occupancy;
    logic            w_accept;
    logic            w_pop;
    logic            w_load_main;
    logic            w_load_skid;
    logic            w_main_from_skid;

    assign w_payload_in = {ctrl_in, aluout_in, flags_in, regdst_in, rt_in,
                           regdata2_in, branaddr_in, jmpaddr_in, pcnext_in};

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_main_valid & out_ready;

    // Next-state and payload load enables; flush overrides every other event.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_load_main = 1'b1;
                        w_state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_pop) begin
                        w_load_main = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = S_TWO;
                    end else if (w_pop) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = S_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // State, valid, ready and occupancy registers, all derived from next state
    // so every handshake output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_EMPTY;
            r_main_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_occupancy  <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_main_valid <= (w_state_nxt != S_EMPTY);
            r_in_ready   <= (w_state_nxt != S_TWO);
            r_occupancy  <= w_state_nxt;
        end
    end

    // Payload registers load only on their enables; flush leaves stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= w_payload_in;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_payload_in;
            end
        end
    end

    assign {w_main_ctrl, aluout_out, flags_out, regdst_out, rt_out,
            regdata2_out, branaddr_out, jmpaddr_out, pcnext_out} = r_main;

    // A bubble must never assert write/read/branch/jump controls.
    assign ctrl_out  = r_main_valid ? w_main_ctrl : '0;
    assign out_valid = r_main_valid;
    assign in_ready  = r_in_ready;
    assign occupancy = r_occupancy;

endmodule
`default_nettype wire

// File: tb/tb_exmem_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_exmem_skid_stage
// Description : Scoreboard testbench for exmem_skid_stage. The driver pushes
//               expected entries on accept; a monitor pops and compares on
//               every pop. Directed checks cover reset, back-pressure, flush,
//               bubble masking and reset mid-stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exmem_skid_stage;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] alu;
        logic [2:0]  flags;
        logic [4:0]  regdst;
        logic [4:0]  rt;
        logic [31:0] rd2;
        logic [31:0] bra;
        logic [31:0] jmp;
        logic [31:0] pcn;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [8:0]  ctrl_in;
    logic [31:0] aluout_in;
    logic [2:0]  flags_in;
    logic [4:0]  regdst_in;
    logic [4:0]  rt_in;
    logic [31:0] regdata2_in;
    logic [31:0] branaddr_in;
    logic [31:0] jmpaddr_in;
    logic [31:0] pcnext_in;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  ctrl_out;
    logic [31:0] aluout_out;
    logic [2:0]  flags_out;
    logic [4:0]  regdst_out;
    logic [4:0]  rt_out;
    logic [31:0] regdata2_out;
    logic [31:0] branaddr_out;
    logic [31:0] jmpaddr_out;
    logic [31:0] pcnext_out;
    logic [1:0]  occupancy;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    exmem_skid_stage #(
        .DWIDTH(32), .AWIDTH(32), .CTRLW(9), .RWIDTH(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .ctrl_in(ctrl_in), .aluout_in(aluout_in),
        .flags_in(flags_in), .regdst_in(regdst_in), .rt_in(rt_in),
        .regdata2_in(regdata2_in), .branaddr_in(branaddr_in),
        .jmpaddr_in(jmpaddr_in), .pcnext_in(pcnext_in),
        .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
        .aluout_out(aluout_out), .flags_out(flags_out),
        .regdst_out(regdst_out), .rt_out(rt_out),
        .regdata2_out(regdata2_out), .branaddr_out(branaddr_out),
        .jmpaddr_out(jmpaddr_out), .pcnext_out(pcnext_out),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [191:0] act,
                       input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Payload derived from the ALU value so every field is distinguishable.
    function automatic exp_t mk(input logic [8:0] c, input logic [31:0] a);
        exp_t e;
        e.ctrl   = c;
        e.alu    = a;
        e.flags  = a[2:0] ^ 3'b101;
        e.regdst = a[4:0] + 5'd1;
        e.rt     = a[8:4];
        e.rd2    = ~a;
        e.bra    = a + 32'h100;
        e.jmp    = a << 2;
        e.pcn    = a + 32'h4;
        return e;
    endfunction

    // One clock of stimulus, starting and ending 1 time unit after posedge.
    task automatic cycle(input logic iv, input logic orr, input logic fl,
                         input logic [8:0] c, input logic [31:0] a);
        exp_t e;
        e = mk(c, a);
        in_valid    = iv;
        out_ready   = orr;
        flush       = fl;
        ctrl_in     = e.ctrl;
        aluout_in   = e.alu;
        flags_in    = e.flags;
        regdst_in   = e.regdst;
        rt_in       = e.rt;
        regdata2_in = e.rd2;
        branaddr_in = e.bra;
        jmpaddr_in  = e.jmp;
        pcnext_in   = e.pcn;
        @(negedge clk);
        if (iv && in_ready && !fl) q.push_back(e);
        @(posedge clk);
        #1;
        if (fl) q.delete();
    endtask

    // Monitor: every pop (valid & ready, no flush) must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (q.size() == 0) begin
                chk("unexpected_pop", {160'd0, aluout_out}, 192'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pop_payload",
                    {10'd0, ctrl_out, aluout_out, flags_out, regdst_out,
                     rt_out, regdata2_out, branaddr_out, jmpaddr_out,
                     pcnext_out},
                    {10'd0, e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        ctrl_in = '0; aluout_in = '0; flags_in = '0; regdst_in = '0;
        rt_in = '0; regdata2_in = '0; branaddr_in = '0; jmpaddr_in = '0;
        pcnext_in = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", {191'd0, out_valid}, 192'd0);
        chk("rst_in_ready",  {191'd0, in_ready},  192'd1);
        chk("rst_occupancy", {190'd0, occupancy}, 192'd0);
        chk("rst_ctrl",      {183'd0, ctrl_out},  192'd0);
        chk("rst_aluout",    {160'd0, aluout_out}, 192'd0);
        chk("rst_pcnext",    {160'd0, pcnext_out}, 192'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming at full rate.
        cycle(1, 1, 0, 9'h023, 32'h10);
        chk("stream_valid", {191'd0, out_valid}, 192'd1);
        chk("stream_alu0",  {160'd0, aluout_out}, 192'h10);
        cycle(1, 1, 0, 9'h023, 32'h20);
        chk("stream_alu1",  {160'd0, aluout_out}, 192'h20);
        cycle(1, 1, 0, 9'h023, 32'h30);
        cycle(1, 1, 0, 9'h023, 32'h40);
        chk("stream_occ",   {190'd0, occupancy}, 192'd1);
        chk("stream_alu3",  {160'd0, aluout_out}, 192'h40);
        cycle(0, 1, 0, 9'h000, 32'h0);
        chk("drain_occ",    {190'd0, occupancy}, 192'd0);

        // Back-pressure into the skid register.
        cycle(1, 0, 0, 9'h045, 32'h10);
        chk("bp_occ1",      {190'd0, occupancy}, 192'd1);
        cycle(1, 0, 0, 9'h045, 32'h20);
        chk("bp_occ2",      {190'd0, occupancy}, 192'd2);
        chk("bp_ready0",    {191'd0, in_ready},  192'd0);
        cycle(1, 0, 0, 9'h045, 32'h30);
        chk("bp_hold_occ",  {190'd0, occupancy}, 192'd2);
        chk("bp_head",      {160'd0, aluout_out}, 192'h10);
        cycle(1, 1, 0, 9'h045, 32'h30);
        chk("bp_pop_occ",   {190'd0, occupancy}, 192'd1);
        chk("bp_pop_head",  {160'd0, aluout_out}, 192'h20);
        chk("bp_ready1",    {191'd0, in_ready},  192'd1);
        // Accept and pop together in ONE: main replaced, skid stays empty.
        cycle(1, 1, 0, 9'h045, 32'h30);
        chk("ap_occ",       {190'd0, occupancy}, 192'd1);
        chk("ap_head",      {160'd0, aluout_out}, 192'h30);
        cycle(0, 1, 0, 9'h000, 32'h0);
        chk("bp_drain",     {190'd0, occupancy}, 192'd0);

        // Flush in TWO drops both entries and the offered one.
        cycle(1, 0, 0, 9'h1FF, 32'h50);
        cycle(1, 0, 0, 9'h1FF, 32'h60);
        chk("fl_pre_occ",   {190'd0, occupancy}, 192'd2);
        cycle(1, 1, 1, 9'h1FF, 32'h70);
        chk("fl_valid",     {191'd0, out_valid}, 192'd0);
        chk("fl_ctrl",      {183'd0, ctrl_out},  192'd0);
        chk("fl_occ",       {190'd0, occupancy}, 192'd0);
        chk("fl_ready",     {191'd0, in_ready},  192'd1);
        chk("fl_stale",     {160'd0, aluout_out}, 192'h50);

        // Bubble masking.
        cycle(1, 0, 0, 9'h0A4, 32'h80);
        chk("bm_ctrl_vis",  {183'd0, ctrl_out},  192'h0A4);
        cycle(0, 1, 0, 9'h000, 32'h0);
        chk("bm_ctrl_mask", {183'd0, ctrl_out},  192'd0);
        chk("bm_stale",     {160'd0, aluout_out}, 192'h80);
        cycle(1, 1, 0, 9'h0A4, 32'h90);
        chk("bm_ctrl_new",  {183'd0, ctrl_out},  192'h0A4);
        cycle(0, 1, 0, 9'h000, 32'h0);

        // Flush while empty.
        cycle(0, 0, 1, 9'h000, 32'h0);
        chk("fe_ready",     {191'd0, in_ready},  192'd1);
        chk("fe_occ",       {190'd0, occupancy}, 192'd0);

        // Asynchronous reset mid-stream with two entries held.
        cycle(1, 0, 0, 9'h1C3, 32'hA0);
        cycle(1, 0, 0, 9'h1C3, 32'hB0);
        chk("mr_pre_occ",   {190'd0, occupancy}, 192'd2);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid",     {191'd0, out_valid}, 192'd0);
        chk("mr_ready",     {191'd0, in_ready},  192'd1);
        chk("mr_occ",       {190'd0, occupancy}, 192'd0);
        chk("mr_ctrl",      {183'd0, ctrl_out},  192'd0);
        chk("mr_alu",       {160'd0, aluout_out}, 192'd0);
        q.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal operation after reset.
        cycle(1, 1, 0, 9'h011, 32'h11);
        chk("post_alu",     {160'd0, aluout_out}, 192'h11);
        cycle(0, 1, 0, 9'h000, 32'h0);
        chk("end_queue",    {160'd0, 32'(q.size())}, 192'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
